risc_fetch_unit: RTL and testbench

RISC_FETCH_UNIT -- requirements
Module: risc_fetch_unit

---
 rtl/risc_fetch_unit.sv | 131 +++++++++++++
 tb/tb_risc_fetch_unit.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/risc_fetch_unit.sv
// Instruction fetch unit: credit-limited memory requests, 2-entry {word, PC} buffer, branch redirect with response discard.
// Optional macro FETCH_ALIGN_CHECK_EN enables the sticky misaligned-target flag and halt.
module risc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr_32,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata_32,
  output logic        instr_valid,
  output logic [31:0] instr_32,
  output logic [31:0] instr_pc_32,
  input  logic        instr_ready,
  input  logic        PCSRC,
  input  logic [31:0] branch_target_32
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        misalign_err
`endif
);

  logic [31:0] r_fetch_pc;
  logic [31:0] r_resp_pc;
  logic        r_rd_ptr;
  logic        r_wr_ptr;
  logic [1:0]  r_count;
  logic [1:0]  r_outstanding;
  logic [1:0]  r_discard;

  logic        w_credit_ok;
  logic        w_halt;
  logic        w_accept;
  logic        w_resp;
  logic        w_drop;
  logic        w_push;
  logic        w_pop;
  logic        w_redirect;
  logic [31:0] w_target;

  // Requests in flight plus buffered words may never exceed the buffer depth.
  assign w_credit_ok = ({1'b0, r_outstanding} + {1'b0, r_count}) < 3'd2;
  assign instr_valid = (r_count != 2'd0);
  assign w_pop       = instr_valid && instr_ready;
  assign w_redirect  = PCSRC && w_pop;
  assign w_target    = branch_target_32 & 32'hFFFF_FFFC;

  assign imem_req     = !rst && !w_redirect && !w_halt && w_credit_ok;
  assign imem_addr_32 = r_fetch_pc;
  assign w_accept     = imem_req && imem_ready;

  // A response with nothing outstanding is spurious and ignored.
  assign w_resp = imem_rvalid && (r_outstanding != 2'd0);
  assign w_drop = w_resp && ((r_discard != 2'd0) || w_redirect);
  assign w_push = w_resp && !w_drop;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
    logic [31:0] r_word;
    logic [31:0] r_pc;
    always_ff @(posedge clk) begin
      if (rst) begin
        r_word <= '0;
        r_pc   <= RESET_PC;
      end else if (w_push && (r_wr_ptr == 1'(gi))) begin
        r_word <= imem_rdata_32;
        r_pc   <= r_resp_pc;
      end
    end
  end

  assign instr_32    = r_rd_ptr ? g_fifo[1].r_word : g_fifo[0].r_word;
  assign instr_pc_32 = r_rd_ptr ? g_fifo[1].r_pc   : g_fifo[0].r_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_rd_ptr      <= 1'b0;
      r_wr_ptr      <= 1'b0;
      r_count       <= 2'd0;
      r_outstanding <= 2'd0;
      r_discard     <= 2'd0;
    end else begin
      if (w_redirect) begin
        r_fetch_pc <= w_target;
        r_resp_pc  <= w_target;
        r_rd_ptr   <= 1'b0;
        r_wr_ptr   <= 1'b0;
        r_count    <= 2'd0;
        // Everything still in flight after this edge belongs to the old path.
        r_discard  <= r_outstanding - {1'b0, w_resp};
      end else begin
        if (w_accept) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (w_push) begin
          r_resp_pc <= r_resp_pc + 32'd4;
          r_wr_ptr  <= ~r_wr_ptr;
        end
        if (w_pop) begin
          r_rd_ptr <= ~r_rd_ptr;
        end
        r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        if (w_drop) begin
          r_discard <= r_discard - 2'd1;
        end
      end
      r_outstanding <= r_outstanding + {1'b0, w_accept} - {1'b0, w_resp};
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_misalign;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_misalign <= 1'b0;
    end else if (w_redirect && (branch_target_32[1:0] != 2'b00)) begin
      r_misalign <= 1'b1;
    end
  end

  assign misalign_err = r_misalign;
  assign w_halt       = r_misalign;
`else
  assign w_halt = 1'b0;
`endif

endmodule

// File: tb/tb_risc_fetch_unit.sv
// Directed self-checking bench for risc_fetch_unit with a queued in-order memory model.
// Honours FETCH_ALIGN_CHECK_EN to match the DUT build.
module tb_risc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr_32;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata_32;
  logic        instr_valid;
  logic [31:0] instr_32;
  logic [31:0] instr_pc_32;
  logic        instr_ready;
  logic        PCSRC;
  logic [31:0] branch_target_32;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        misalign_err;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  risc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk              (clk),
    .rst              (rst),
    .imem_req         (imem_req),
    .imem_addr_32     (imem_addr_32),
    .imem_ready       (imem_ready),
    .imem_rvalid      (imem_rvalid),
    .imem_rdata_32    (imem_rdata_32),
    .instr_valid      (instr_valid),
    .instr_32         (instr_32),
    .instr_pc_32      (instr_pc_32),
    .instr_ready      (instr_ready),
    .PCSRC            (PCSRC),
    .branch_target_32 (branch_target_32)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .misalign_err     (misalign_err)
`endif
  );

  // Memory model: accepted addresses return in order, mem_lat cycles later, unless held.
  logic [31:0] q_addr[$];
  int          q_due[$];
  int          cyc = 0;
  int          mem_lat = 1;
  bit          mem_hold = 0;

  // Per-cycle samples taken mid-cycle, away from the rising edge.
  logic        s_req, s_acc, s_valid, s_pop, s_rvalid, s_mis;
  logic [31:0] s_addr, s_pc, s_word;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
  endfunction

  task automatic step();
    if (rst) begin
      q_addr.delete();
      q_due.delete();
      imem_rvalid   = 1'b0;
      imem_rdata_32 = 32'h0;
    end else if (!mem_hold && q_addr.size() > 0 && q_due[0] <= cyc) begin
      imem_rvalid   = 1'b1;
      imem_rdata_32 = mem_word(q_addr[0]);
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end else begin
      imem_rvalid   = 1'b0;
      imem_rdata_32 = 32'h0;
    end
    #1;
    s_req    = imem_req;
    s_acc    = imem_req && imem_ready;
    s_addr   = imem_addr_32;
    s_valid  = instr_valid;
    s_pop    = instr_valid && instr_ready;
    s_pc     = instr_pc_32;
    s_word   = instr_32;
    s_rvalid = imem_rvalid;
`ifdef FETCH_ALIGN_CHECK_EN
    s_mis    = misalign_err;
`else
    s_mis    = 1'b0;
`endif
    if (!rst && s_acc) begin
      q_addr.push_back(s_addr);
      q_due.push_back(cyc + mem_lat);
    end
    if (s_pop) $display("cycle %0d: pop pc=%08h word=%08h", cyc, s_pc, s_word);
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    imem_ready       = 1'b1;
    instr_ready      = 1'b0;
    PCSRC            = 1'b0;
    branch_target_32 = 32'h0;
    mem_hold         = 1'b0;
    mem_lat          = 1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst              = 1'b1;
    imem_ready       = 1'b1;
    instr_ready      = 1'b1;
    PCSRC            = 1'b0;
    branch_target_32 = 32'h0;
    mem_hold         = 1'b0;
    step();
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL reset_req_first: got %b want 0", s_req); end
    step();
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", s_req); end
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", s_valid); end
    checks++; if (s_word !== 32'h0) begin errors++; $display("FAIL reset_instr: got %08h want 00000000", s_word); end
    checks++; if (s_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %08h want 00000000", s_pc); end
    checks++; if (s_mis !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b want 0", s_mis); end
    rst = 1'b0;
    step();
    checks++; if (s_req !== 1'b1) begin errors++; $display("FAIL first_req_after_reset: got %b want 1", s_req); end
    checks++; if (s_addr !== 32'h0) begin errors++; $display("FAIL first_addr_after_reset: got %08h want 00000000", s_addr); end
  endtask

  task automatic test_sequential();
    logic [31:0] acc_list[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_word[$];
    logic        v1, v2;
    logic [31:0] exp;
    v1 = 1'bx;
    v2 = 1'bx;
    do_reset();
    instr_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      if (s_acc) acc_list.push_back(s_addr);
      if (s_pop) begin pop_pc.push_back(s_pc); pop_word.push_back(s_word); end
      if (i == 1) v1 = s_valid;
      if (i == 2) v2 = s_valid;
    end
    checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL seq_valid_in_rvalid_cycle: got %b want 0", v1); end
    checks++; if (v2 !== 1'b1) begin errors++; $display("FAIL seq_valid_next_cycle: got %b want 1", v2); end
    for (int k = 0; k < 4; k++) begin
      exp = 32'(k * 4);
      checks++;
      if (k >= acc_list.size()) begin errors++; $display("FAIL seq_addr[%0d]: got none want %08h", k, exp); end
      else if (acc_list[k] !== exp) begin errors++; $display("FAIL seq_addr[%0d]: got %08h want %08h", k, acc_list[k], exp); end
    end
    for (int k = 0; k < 3; k++) begin
      exp = 32'(k * 4);
      checks++;
      if (k >= pop_pc.size()) begin errors++; $display("FAIL seq_pop[%0d]: got none want pc %08h", k, exp); end
      else begin
        if (pop_pc[k] !== exp) begin errors++; $display("FAIL seq_pop_pc[%0d]: got %08h want %08h", k, pop_pc[k], exp); end
        checks++;
        if (pop_word[k] !== mem_word(exp)) begin errors++; $display("FAIL seq_pop_word[%0d]: got %08h want %08h", k, pop_word[k], mem_word(exp)); end
      end
    end
  endtask

  task automatic test_backpressure();
    int          n_acc;
    logic [31:0] pop_pc[$];
    logic [31:0] pop_word[$];
    logic [31:0] exp;
    n_acc = 0;
    do_reset();
    instr_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (s_acc) n_acc++;
    end
    checks++; if (n_acc != 2) begin errors++; $display("FAIL bp_accept_count: got %0d want 2", n_acc); end
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL bp_req_when_full: got %b want 0", s_req); end
    checks++; if (s_valid !== 1'b1 || s_pc !== 32'h0) begin errors++; $display("FAIL bp_head: got valid=%b pc=%08h want valid=1 pc=00000000", s_valid, s_pc); end
    instr_ready = 1'b1;
    for (int i = 0; i < 30 && pop_pc.size() < 4; i++) begin
      step();
      if (s_pop) begin pop_pc.push_back(s_pc); pop_word.push_back(s_word); end
    end
    checks++; if (pop_pc.size() != 4) begin errors++; $display("FAIL bp_pop_count: got %0d want 4", pop_pc.size()); end
    for (int k = 0; k < 4 && k < pop_pc.size(); k++) begin
      exp = 32'(k * 4);
      checks++;
      if (pop_pc[k] !== exp || pop_word[k] !== mem_word(exp)) begin
        errors++;
        $display("FAIL bp_pop[%0d]: got pc=%08h word=%08h want pc=%08h word=%08h", k, pop_pc[k], pop_word[k], exp, mem_word(exp));
      end
    end
  endtask

  // Head PC 4 redirected to 0x40 while PC 8 is in flight; the PC 8 response
  // returns either after the redirect or in the redirect cycle itself.
  task automatic test_redirect(input bit same_cycle);
    bit          hold_tbl[7];
    logic [31:0] first_acc, first_pop_pc, first_pop_word, second_pop_pc;
    int          n_pop;
    bit          got_acc;
    hold_tbl = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    if (same_cycle) hold_tbl[6] = 1'b0;
    got_acc = 1'b0;
    n_pop = 0;
    first_acc = 32'hDEAD_BEEF;
    first_pop_pc = 32'hDEAD_BEEF;
    first_pop_word = 32'hDEAD_BEEF;
    second_pop_pc = 32'hDEAD_BEEF;
    do_reset();
    instr_ready = 1'b1;
    branch_target_32 = 32'h0000_0040;
    for (int i = 0; i < 7; i++) begin
      mem_hold = hold_tbl[i];
      PCSRC = (i == 6);
      step();
    end
    checks++; if (!(s_pop === 1'b1 && s_pc === 32'h4)) begin errors++; $display("FAIL redir%0d_head: got pop=%b pc=%08h want pop=1 pc=00000004", same_cycle, s_pop, s_pc); end
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL redir%0d_req_in_redirect: got %b want 0", same_cycle, s_req); end
    PCSRC = 1'b0;
    mem_hold = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (s_acc && !got_acc) begin first_acc = s_addr; got_acc = 1'b1; end
      if (s_pop) begin
        if (n_pop == 0) begin first_pop_pc = s_pc; first_pop_word = s_word; end
        if (n_pop == 1) second_pop_pc = s_pc;
        n_pop++;
      end
    end
    checks++; if (first_acc !== 32'h40) begin errors++; $display("FAIL redir%0d_first_addr: got %08h want 00000040", same_cycle, first_acc); end
    checks++; if (first_pop_pc !== 32'h40) begin errors++; $display("FAIL redir%0d_first_pc: got %08h want 00000040", same_cycle, first_pop_pc); end
    checks++; if (first_pop_word !== mem_word(32'h40)) begin errors++; $display("FAIL redir%0d_first_word: got %08h want %08h", same_cycle, first_pop_word, mem_word(32'h40)); end
    checks++; if (second_pop_pc !== 32'h44) begin errors++; $display("FAIL redir%0d_second_pc: got %08h want 00000044", same_cycle, second_pop_pc); end
  endtask

  task automatic test_pcsrc_ignored();
    logic [31:0] acc_list[$];
    logic [31:0] pop_pc[$];
    logic [31:0] exp;
    do_reset();
    branch_target_32 = 32'h0000_0080;
    PCSRC = 1'b1;
    instr_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      if (s_acc) acc_list.push_back(s_addr);
    end
    instr_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (s_acc) acc_list.push_back(s_addr);
    end
    PCSRC = 1'b0;
    instr_ready = 1'b1;
    for (int i = 0; i < 20 && pop_pc.size() < 3; i++) begin
      step();
      if (s_acc) acc_list.push_back(s_addr);
      if (s_pop) pop_pc.push_back(s_pc);
    end
    for (int k = 0; k < 3; k++) begin
      exp = 32'(k * 4);
      checks++;
      if (k >= acc_list.size()) begin errors++; $display("FAIL ign_addr[%0d]: got none want %08h", k, exp); end
      else if (acc_list[k] !== exp) begin errors++; $display("FAIL ign_addr[%0d]: got %08h want %08h", k, acc_list[k], exp); end
      checks++;
      if (k >= pop_pc.size()) begin errors++; $display("FAIL ign_pop[%0d]: got none want %08h", k, exp); end
      else if (pop_pc[k] !== exp) begin errors++; $display("FAIL ign_pop[%0d]: got %08h want %08h", k, pop_pc[k], exp); end
    end
  endtask

  // Redirect on the first popped instruction (PC 0) to the given target.
  task automatic redirect_at_first_pop(input logic [31:0] target, input string tag);
    bit found;
    found = 1'b0;
    do_reset();
    instr_ready = 1'b1;
    branch_target_32 = target;
    PCSRC = 1'b1;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (s_pop) found = 1'b1;
    end
    PCSRC = 1'b0;
    checks++;
    if (!found) begin errors++; $display("FAIL %s_redirect: got no head within 10 cycles want pop of pc 00000000", tag); end
    else if (s_pc !== 32'h0) begin errors++; $display("FAIL %s_redirect_head: got %08h want 00000000", tag, s_pc); end
  endtask

  task automatic test_wrap();
    logic [31:0] acc_list[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_word[$];
    logic [31:0] exp_pc[2];
    exp_pc = '{32'hFFFF_FFFC, 32'h0000_0000};
    redirect_at_first_pop(32'hFFFF_FFFC, "wrap");
    for (int i = 0; i < 12; i++) begin
      step();
      if (s_acc) acc_list.push_back(s_addr);
      if (s_pop) begin pop_pc.push_back(s_pc); pop_word.push_back(s_word); end
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (k >= acc_list.size()) begin errors++; $display("FAIL wrap_addr[%0d]: got none want %08h", k, exp_pc[k]); end
      else if (acc_list[k] !== exp_pc[k]) begin errors++; $display("FAIL wrap_addr[%0d]: got %08h want %08h", k, acc_list[k], exp_pc[k]); end
      checks++;
      if (k >= pop_pc.size()) begin errors++; $display("FAIL wrap_pop[%0d]: got none want %08h", k, exp_pc[k]); end
      else if (pop_pc[k] !== exp_pc[k] || pop_word[k] !== mem_word(exp_pc[k])) begin
        errors++;
        $display("FAIL wrap_pop[%0d]: got pc=%08h word=%08h want pc=%08h word=%08h", k, pop_pc[k], pop_word[k], exp_pc[k], mem_word(exp_pc[k]));
      end
    end
  endtask

  task automatic test_misalign();
`ifdef FETCH_ALIGN_CHECK_EN
    int n_req;
    n_req = 0;
    redirect_at_first_pop(32'h0000_0042, "mis");
    for (int i = 0; i < 8; i++) begin
      step();
      if (s_req) n_req++;
    end
    checks++; if (s_mis !== 1'b1) begin errors++; $display("FAIL mis_flag: got %b want 1", s_mis); end
    checks++; if (n_req != 0) begin errors++; $display("FAIL mis_halt: got %0d requests want 0", n_req); end
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL mis_flush: got valid=%b want 0", s_valid); end
    rst = 1'b1;
    step();
    step();
    checks++; if (s_mis !== 1'b0) begin errors++; $display("FAIL mis_cleared_by_reset: got %b want 0", s_mis); end
    rst = 1'b0;
    step();
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h0) begin errors++; $display("FAIL mis_resume: got req=%b addr=%08h want req=1 addr=00000000", s_req, s_addr); end
`else
    logic [31:0] first_acc, first_pop_pc, first_pop_word;
    bit          got_acc, got_pop;
    got_acc = 1'b0;
    got_pop = 1'b0;
    first_acc = 32'hDEAD_BEEF;
    first_pop_pc = 32'hDEAD_BEEF;
    first_pop_word = 32'hDEAD_BEEF;
    redirect_at_first_pop(32'h0000_0042, "mis");
    for (int i = 0; i < 12; i++) begin
      step();
      if (s_acc && !got_acc) begin first_acc = s_addr; got_acc = 1'b1; end
      if (s_pop && !got_pop) begin first_pop_pc = s_pc; first_pop_word = s_word; got_pop = 1'b1; end
    end
    checks++; if (first_acc !== 32'h40) begin errors++; $display("FAIL mis_addr: got %08h want 00000040", first_acc); end
    checks++; if (first_pop_pc !== 32'h40) begin errors++; $display("FAIL mis_pop_pc: got %08h want 00000040", first_pop_pc); end
    checks++; if (first_pop_word !== mem_word(32'h40)) begin errors++; $display("FAIL mis_pop_word: got %08h want %08h", first_pop_word, mem_word(32'h40)); end
`endif
  endtask

  initial begin
    rst = 1'b1;
    imem_ready = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata_32 = 32'h0;
    instr_ready = 1'b0;
    PCSRC = 1'b0;
    branch_target_32 = 32'h0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect(1'b0);
    test_redirect(1'b1);
    test_pcsrc_ignored();
    test_wrap();
    test_misalign();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached without completing");
    $fatal(1, "watchdog expired");
  end

endmodule
